mux_n_to_1_pipe: RTL and testbench
==================================

MUX_N_TO_1_PIPE -- requirements
Module: mux_n_to_1_pipe

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, meaning data bit width of each input and of the output.
REQ-002 The block SHALL provide parameter N_IN, default 4, meaning number of data inputs (legal range 2..16).
REQ-003 The block SHALL provide parameter BAD_VAL, default 32'hDEADBEEF, meaning output value for an out-of-range select, truncated or zero-extended to WIDTH.
REQ-004 The block SHALL provide local parameter SEL_W = max(1, clog2(N_IN)), meaning select width.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 in_valid  input  1  upstream offers sel/data this cycle.
REQ-008 in_ready  output  1  block accepts this cycle.
REQ-009 sel  input  SEL_W  index of input to forward.
REQ-010 data  input  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-011 flush  input  1  discards all buffered and incoming entries.
REQ-012 out_valid  output  1  out_data/out_sel_err are valid.
REQ-013 out_ready  input  1  downstream consumes this cycle.
REQ-014 out_data  output  WIDTH  selected word.
REQ-015 out_sel_err  output  1  the current output entry had an out-of-range select.
REQ-016 err_sticky  output  1  an out-of-range select has been accepted since reset.
REQ-017 err_count  output  8  saturating count of accepted out-of-range selects.

Function
REQ-018 Accept SHALL occur when in_valid and in_ready are both high and flush is low.
REQ-019 Pop SHALL occur when out_valid and out_ready are both high and flush is low.
REQ-020 On accept, the block SHALL select data[sel] if sel < N_IN, else BAD_VAL with error bit set, and store the word and error bit in a 2-entry FIFO buffer.
REQ-021 in_ready SHALL be high iff the buffer holds fewer than 2 entries; it SHALL be registered-state-derived and SHALL NOT depend combinationally on out_ready.
REQ-022 out_valid SHALL be high iff the buffer holds at least 1 entry; out_data and out_sel_err SHALL come from the oldest entry.
REQ-023 Latency SHALL be 1 cycle: a word accepted at edge t into an empty buffer SHALL appear with out_valid=1 after edge t.
REQ-024 Entries SHALL leave in acceptance order.
REQ-025 Simultaneous accept and pop with 1 entry SHALL leave the count at 1, holding the new word.
REQ-026 Simultaneous accept and pop with 0 entries is impossible (out_valid=0); accept alone SHALL apply.
REQ-027 With 2 entries, in_ready SHALL be low; a pop SHALL raise in_ready on the following cycle.
REQ-028 While out_valid=1 and out_ready=0, out_data and out_sel_err SHALL hold stable.
REQ-029 flush SHALL empty the buffer at the next edge regardless of in_valid/out_ready; any offer that cycle SHALL be dropped and SHALL NOT count as an error.
REQ-030 err_sticky SHALL set on the first accepted out-of-range select and clear only on reset.
REQ-031 err_count SHALL increment by 1 per accepted out-of-range select and saturate at 255.
REQ-032 When N_IN is a power of two, the out-of-range path SHALL be unreachable; err_sticky and err_count SHALL remain 0.

Reset
REQ-033 On rst_n low, the block SHALL immediately clear the buffer count, out_valid, out_sel_err, err_sticky and err_count to 0 and drive out_data to 0.
REQ-034 in_ready SHALL be 1 when rst_n is low and on the first cycle after release.
REQ-035 Reset asserted mid-transfer SHALL discard all buffered entries; no partial entry SHALL survive.

Structure
REQ-036 A shared package SHALL hold the default BAD_VAL constant, the error-counter width (8), and a typedef for a buffer entry (word plus error bit).
REQ-037 The index-decode/select logic SHALL be a combinational sub-module mux_n_sel, parameterised by WIDTH, N_IN and BAD_VAL, outputting word and error bit; the FIFO buffer and counters reside in mux_n_to_1_pipe.

Verification
REQ-038 Basic forwarding (N_IN=4, data={44,33,22,11}): sel=2 with out_ready=1 -> out_data=33 one cycle later, out_sel_err=0.
REQ-039 Out-of-range (N_IN=3): sel=3 accepted -> out_data=BAD_VAL, out_sel_err=1, err_sticky=1, err_count=1.
REQ-040 Backpressure: out_ready=0, three offers of sel=0,1,2 -> first two accepted, in_ready=0, third held; release -> outputs 11,22,33 in order.
REQ-041 Flush: buffer full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, err_count unchanged.
REQ-042 Saturation (N_IN=3): 300 accepted sel=3 -> err_count=255, err_sticky=1.
REQ-043 Async reset: assert rst_n=0 between edges with 2 entries buffered -> out_valid=0 and err_count=0 immediately, in_ready=1.

Source files
------------

// File: rtl/mux_n_to_1_pipe_pkg.sv
// rtl/mux_n_to_1_pipe_pkg.sv - shared constants and entry type for the pipelined N-to-1 mux
package mux_n_to_1_pipe_pkg;

    localparam logic [31:0] BAD_VAL_DEFAULT = 32'hDEADBEEF;
    localparam int          ERR_CNT_W       = 8;
    localparam int          DEF_WIDTH       = 32;

    // One buffered result at the default data width: selected word plus range-error flag.
    typedef struct packed {
        logic                 err;
        logic [DEF_WIDTH-1:0] word;
    } entry_t;

endpackage

// File: rtl/mux_n_sel.sv
// rtl/mux_n_sel.sv - combinational index decode and word select with out-of-range substitute
module mux_n_sel
    import mux_n_to_1_pipe_pkg::*;
#(
    parameter int          WIDTH   = 32,
    parameter int          N_IN    = 4,
    parameter logic [31:0] BAD_VAL = BAD_VAL_DEFAULT,
    localparam int         SEL_W   = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] data,
    output logic [WIDTH-1:0]      word,
    output logic                  err
);

    localparam logic [WIDTH-1:0] BAD_W = WIDTH'(BAD_VAL);

    // Any select value not matching a real input falls through to the substitute word.
    always_comb begin
        word = BAD_W;
        err  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                word = data[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// rtl/mux_n_to_1_pipe.sv - N-to-1 mux with 2-entry output buffer and select-error tracking
module mux_n_to_1_pipe
    import mux_n_to_1_pipe_pkg::*;
#(
    parameter int          WIDTH   = 32,
    parameter int          N_IN    = 4,
    parameter logic [31:0] BAD_VAL = BAD_VAL_DEFAULT,
    localparam int         SEL_W   = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_sel_err,
    output logic                  err_sticky,
    output logic [ERR_CNT_W-1:0]  err_count
);

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] word;
    } slot_t;

    slot_t            mem [2];
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WIDTH-1:0] sel_word;
    logic             sel_err;
    logic             accept;
    logic             pop;

    mux_n_sel #(
        .WIDTH   (WIDTH),
        .N_IN    (N_IN),
        .BAD_VAL (BAD_VAL)
    ) u_sel (
        .sel  (sel),
        .data (data),
        .word (sel_word),
        .err  (sel_err)
    );

    // Both handshakes derive only from registered occupancy, never from out_ready.
    assign in_ready    = (count != 2'd2);
    assign out_valid   = (count != 2'd0);
    assign out_data    = mem[rd_ptr].word;
    assign out_sel_err = mem[rd_ptr].err;

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            mem[0]     <= '0;
            mem[1]     <= '0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= '{err: sel_err, word: sel_word};
                wr_ptr      <= ~wr_ptr;
                if (sel_err) begin
                    err_sticky <= 1'b1;
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// tb/tb_mux_n_to_1_pipe.sv - directed self-checking bench for mux_n_to_1_pipe
module tb_mux_n_to_1_pipe;
    import mux_n_to_1_pipe_pkg::*;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Four-input instance, power-of-two: range errors are unreachable.
    logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_sel_err, a_sticky;
    logic [1:0]   a_sel;
    logic [127:0] a_data;
    logic [31:0]  a_out_data;
    logic [7:0]   a_count;

    // Three-input instance: select 3 is out of range.
    logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err, b_sticky;
    logic [1:0]   b_sel;
    logic [95:0]  b_data;
    logic [31:0]  b_out_data;
    logic [7:0]   b_count;

    entry_t exp_e;

    mux_n_to_1_pipe #(.WIDTH(32), .N_IN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sel(a_sel), .data(a_data), .flush(a_flush), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_sel_err(a_sel_err),
        .err_sticky(a_sticky), .err_count(a_count)
    );

    mux_n_to_1_pipe #(.WIDTH(32), .N_IN(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel), .data(b_data), .flush(b_flush), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_sel_err(b_sel_err),
        .err_sticky(b_sticky), .err_count(b_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 0; a_flush = 0; a_out_ready = 0; a_sel = 0;
        b_in_valid = 0; b_flush = 0; b_out_ready = 0; b_sel = 0;
        a_data = {32'h44, 32'h33, 32'h22, 32'h11};
        b_data = {32'h33, 32'h22, 32'h11};
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_a rdy=%b vld=%b data=%h cnt=%0d exp 1 0 0 0", a_in_ready, a_out_valid, a_out_data, a_count);
        end
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_sticky !== 1'b0 || b_sel_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_b rdy=%b vld=%b sticky=%b err=%b exp 1 0 0 0", b_in_ready, b_out_valid, b_sticky, b_sel_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset rdy=%b vld=%b exp 1 0", a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_forward();
        a_in_valid = 1; a_sel = 2'd2; a_out_ready = 1;
        step();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'h33 || a_sel_err !== 1'b0) begin
            errors++;
            $display("FAIL fwd_sel2 vld=%b data=%h err=%b exp 1 33 0", a_out_valid, a_out_data, a_sel_err);
        end
        a_sel = 2'd3;
        step();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'h44 || a_sel_err !== 1'b0 || a_sticky !== 1'b0) begin
            errors++;
            $display("FAIL fwd_sel3_pow2 vld=%b data=%h err=%b sticky=%b exp 1 44 0 0", a_out_valid, a_out_data, a_sel_err, a_sticky);
        end
        a_in_valid = 0;
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_count !== 8'd0) begin
            errors++;
            $display("FAIL fwd_drain vld=%b cnt=%0d exp 0 0", a_out_valid, a_count);
        end
    endtask

    task automatic test_out_of_range();
        b_in_valid = 1; b_sel = 2'd3; b_out_ready = 0;
        step();
        exp_e = '{err: 1'b1, word: BAD_VAL_DEFAULT};
        checks++;
        if ({b_sel_err, b_out_data} !== exp_e || b_sticky !== 1'b1 || b_count !== 8'd1) begin
            errors++;
            $display("FAIL oor_entry err=%b data=%h sticky=%b cnt=%0d exp 1 deadbeef 1 1", b_sel_err, b_out_data, b_sticky, b_count);
        end
        b_in_valid = 0; b_out_ready = 1;
        step();
        b_in_valid = 1; b_sel = 2'd2;
        step();
        exp_e = '{err: 1'b0, word: 32'h33};
        checks++;
        if ({b_sel_err, b_out_data} !== exp_e || b_count !== 8'd1) begin
            errors++;
            $display("FAIL oor_then_valid err=%b data=%h cnt=%0d exp 0 33 1", b_sel_err, b_out_data, b_count);
        end
        b_in_valid = 0;
        step();
    endtask

    task automatic test_backpressure();
        a_out_ready = 0; a_in_valid = 1; a_sel = 2'd0;
        step();
        a_sel = 2'd1;
        step();
        checks++;
        if (a_in_ready !== 1'b0 || a_out_data !== 32'h11) begin
            errors++;
            $display("FAIL bp_full rdy=%b data=%h exp 0 11", a_in_ready, a_out_data);
        end
        a_sel = 2'd2;
        step();
        checks++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== 32'h11) begin
            errors++;
            $display("FAIL bp_hold rdy=%b vld=%b data=%h exp 0 1 11", a_in_ready, a_out_valid, a_out_data);
        end
        a_out_ready = 1;
        step();
        checks++;
        if (a_out_data !== 32'h22 || a_in_ready !== 1'b1 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop1 data=%h rdy=%b vld=%b exp 22 1 1", a_out_data, a_in_ready, a_out_valid);
        end
        step();
        checks++;
        if (a_out_data !== 32'h33 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop2 data=%h vld=%b exp 33 1", a_out_data, a_out_valid);
        end
        a_in_valid = 0;
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty vld=%b exp 0", a_out_valid);
        end
    endtask

    task automatic test_flush();
        b_out_ready = 0; b_in_valid = 1; b_sel = 2'd0;
        step();
        b_sel = 2'd1;
        step();
        checks++;
        if (b_in_ready !== 1'b0 || b_count !== 8'd1) begin
            errors++;
            $display("FAIL flush_fill rdy=%b cnt=%0d exp 0 1", b_in_ready, b_count);
        end
        b_flush = 1; b_sel = 2'd3; b_out_ready = 1;
        step();
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_count !== 8'd1) begin
            errors++;
            $display("FAIL flush_empty vld=%b rdy=%b cnt=%0d exp 0 1 1", b_out_valid, b_in_ready, b_count);
        end
        b_flush = 0; b_in_valid = 0;
        step();
    endtask

    task automatic test_saturation();
        b_out_ready = 1; b_in_valid = 1; b_sel = 2'd3;
        repeat (100) step();
        checks++;
        if (b_count !== 8'd101) begin
            errors++;
            $display("FAIL sat_mid cnt=%0d exp 101", b_count);
        end
        repeat (154) step();
        checks++;
        if (b_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_reach cnt=%0d exp 255", b_count);
        end
        repeat (46) step();
        checks++;
        if (b_count !== 8'd255 || b_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold cnt=%0d sticky=%b exp 255 1", b_count, b_sticky);
        end
        b_in_valid = 0;
        step();
    endtask

    task automatic test_async_reset();
        a_out_ready = 0; a_in_valid = 1; a_sel = 2'd0;
        step();
        a_sel = 2'd1;
        step();
        checks++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ar_full vld=%b rdy=%b exp 1 0", a_out_valid, a_in_ready);
        end
        #2;
        a_in_valid = 0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 32'h0) begin
            errors++;
            $display("FAIL ar_clear_a vld=%b rdy=%b data=%h exp 0 1 0", a_out_valid, a_in_ready, a_out_data);
        end
        checks++;
        if (b_count !== 8'd0 || b_sticky !== 1'b0) begin
            errors++;
            $display("FAIL ar_clear_b cnt=%0d sticky=%b exp 0 0", b_count, b_sticky);
        end
        #2;
        rst_n = 1'b1;
        step();
        a_in_valid = 1; a_sel = 2'd1; a_out_ready = 1;
        step();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'h22) begin
            errors++;
            $display("FAIL ar_resume vld=%b data=%h exp 1 22", a_out_valid, a_out_data);
        end
        a_in_valid = 0;
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_no_stale vld=%b exp 0", a_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_out_of_range();
        test_backpressure();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
